// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's memory port (master) and the memory responder (slave).
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_read;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [3:0]            req_wstrb;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_ready;
  logic                  resp_error;
  logic                  busy;

  modport master (
    output req_read, req_write, req_addr, req_wdata, req_wstrb,
    input  resp_rdata, resp_ready, resp_error, busy
  );

  modport slave (
    input  req_read, req_write, req_addr, req_wdata, req_wstrb,
    output resp_rdata, resp_ready, resp_error, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised RAM responder with WAIT_STATES wait cycles and a one-cycle resp_ready pulse.
// Optional MEM_RESP_BYTE_STROBE_EN: when defined, writes honour req_wstrb per byte lane.
module mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic             clk,
  input logic             rst_n,
  mem_responder_if.slave  bus
);

  localparam int                  IDXW  = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH_WORDS) << 2;
  localparam logic [3:0]          WLOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, next_state;
  logic [3:0]            cnt;
  logic [IDXW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  write_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ready_q;
  logic                  error_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] ram [DEPTH_WORDS];

  logic                  accept;
  logic                  req_err;
  logic                  rd_err;
  logic                  rd_write;
  logic [IDXW-1:0]       rd_idx;

`ifdef MEM_RESP_BYTE_STROBE_EN
  logic [3:0]            wstrb_q;
`endif

  assign req_err = (bus.req_addr[1:0] != 2'b00) ||
                   ({1'b0, bus.req_addr} >= LIMIT) ||
                   (bus.req_read && bus.req_write);

  // With zero wait states RESP is entered on the accepting edge, so the
  // response source must come straight from the request rather than the latches.
  assign rd_err   = accept ? req_err       : err_q;
  assign rd_write = accept ? bus.req_write : write_q;
  assign rd_idx   = accept ? bus.req_addr[IDXW+1:2] : idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_read || bus.req_write) begin
          accept     = 1'b1;
          next_state = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT:    if (cnt == 4'd0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= WLOAD;
        idx_q   <= bus.req_addr[IDXW+1:2];
        wdata_q <= bus.req_wdata;
        write_q <= bus.req_write;
        err_q   <= req_err;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      ready_q <= (next_state == RESP);
      error_q <= (next_state == RESP) && rd_err;
      busy_q  <= (next_state != IDLE);
      if (next_state == RESP) begin
        if (rd_err)         rdata_q <= '0;
        else if (!rd_write) rdata_q <= ram[rd_idx];
      end
    end
  end

`ifdef MEM_RESP_BYTE_STROBE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      wstrb_q <= 4'd0;
    else if (accept) wstrb_q <= bus.req_wstrb;
  end
`endif

  // RAM is intentionally not reset; the write lands on the edge that ends RESP.
  always_ff @(posedge clk) begin
    if (state == RESP && write_q && !err_q) begin
`ifdef MEM_RESP_BYTE_STROBE_EN
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) ram[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
`else
      ram[idx_q] <= wdata_q;
`endif
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_ready = ready_q;
  assign bus.resp_error = error_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: a 1-wait-state responder driven from a vector table, a 0-wait-state one by hand.
module tb_mem_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1();
  mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0();

  mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(0))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

`ifdef MEM_RESP_BYTE_STROBE_EN
  localparam logic [31:0] MERGED = 32'h11BB33DD;
  localparam logic [31:0] W10    = 32'hDEADBEEF;
`else
  localparam logic [31:0] MERGED = 32'hAABBCCDD;
  localparam logic [31:0] W10    = 32'h00000055;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t q1[$];
  exp_t q0[$];
  exp_t e1, e0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every response pulse pops one expectation, including latency.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus1.resp_ready) begin
        if (q1.size() == 0) check("dut1 unexpected resp_ready", 32'd1, 32'd0);
        else begin
          e1 = q1.pop_front();
          check("dut1 rdata", bus1.resp_rdata, e1.rdata);
          check("dut1 error", {31'd0, bus1.resp_error}, {31'd0, e1.err});
          check("dut1 latency", cyc - e1.acc, 32'd1);
        end
      end
      if (bus0.resp_ready) begin
        if (q0.size() == 0) check("dut0 unexpected resp_ready", 32'd1, 32'd0);
        else begin
          e0 = q0.pop_front();
          check("dut0 rdata", bus0.resp_rdata, e0.rdata);
          check("dut0 error", {31'd0, bus0.resp_error}, {31'd0, e0.err});
          check("dut0 latency", cyc - e0.acc, 32'd0);
        end
      end
    end
  end

  task automatic drive(input int which, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (which == 1) begin
      bus1.req_read = rd; bus1.req_write = wr; bus1.req_addr = a;
      bus1.req_wdata = d; bus1.req_wstrb = s;
    end else begin
      bus0.req_read = rd; bus0.req_write = wr; bus0.req_addr = a;
      bus0.req_wdata = d; bus0.req_wstrb = s;
    end
  endtask

  task automatic wait_idle(input int which);
    bit done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (which == 1 && q1.size() == 0 && !bus1.busy) begin done = 1'b1; break; end
      if (which == 0 && q0.size() == 0 && !bus0.busy) begin done = 1'b1; break; end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d response timeout: still pending after 40 cycles", which);
    end
  endtask

  task automatic req(input int which, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] er, input logic ee);
    @(negedge clk);
    drive(which, rd, wr, a, d, s);
    if (which == 1) q1.push_back('{er, ee, cyc + 1});
    else            q0.push_back('{er, ee, cyc + 1});
    @(negedge clk);
    drive(which, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    wait_idle(which);
  endtask

  initial begin
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

    vecs.push_back('{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h20,       32'hCAFEF00D, 4'hF, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h12,       32'h0,        4'hF, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h1000,     32'h0,        4'hF, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h20,       32'h12345678, 4'hF, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h20,       32'h0,        4'hF, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h8,        32'h11223344, 4'hF, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h8,        32'hAABBCCDD, 4'h5, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h8,        32'h0,        4'hF, MERGED,       1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'hFFC,      32'h0BADF00D, 4'hF, MERGED,       1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'hFFC,      32'h0,        4'hF, 32'h0BADF00D, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h10,       32'h00000055, 4'h0, 32'h0BADF00D, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        4'hF, W10,          1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFFC, 32'h0,        4'hF, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'hFFC,      32'h0,        4'hF, 32'h0BADF00D, 1'b0});

    repeat (2) @(negedge clk);
    check("dut1 reset rdata", bus1.resp_rdata, 32'd0);
    check("dut1 reset ready/error/busy", {29'd0, bus1.resp_ready, bus1.resp_error, bus1.busy}, 32'd0);
    check("dut0 reset rdata", bus0.resp_rdata, 32'd0);
    check("dut0 reset ready/error/busy", {29'd0, bus0.resp_ready, bus0.resp_error, bus0.busy}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      req(1, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
          vecs[i].exp_rdata, vecs[i].exp_err);
      check("dut1 idle error clear", {31'd0, bus1.resp_error}, 32'd0);
      check("dut1 idle rdata held", bus1.resp_rdata, vecs[i].exp_rdata);
    end

    // Zero wait states: response and busy both last exactly one cycle.
    req(0, 1'b0, 1'b1, 32'h0, 32'h00500093, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    q0.push_back('{32'h00500093, 1'b0, cyc + 1});
    @(negedge clk);
    check("dut0 busy in resp", {31'd0, bus0.busy}, 32'd1);
    check("dut0 ready in resp", {31'd0, bus0.resp_ready}, 32'd1);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    check("dut0 busy after resp", {31'd0, bus0.busy}, 32'd0);
    check("dut0 ready after resp", {31'd0, bus0.resp_ready}, 32'd0);

    // Strobes raised while busy must be ignored, not queued.
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    q1.push_back('{W10, 1'b0, cyc + 1});
    @(negedge clk);
    check("dut1 busy in wait", {31'd0, bus1.busy}, 32'd1);
    drive(1, 1'b0, 1'b1, 32'h10, 32'h0, 4'hF);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    wait_idle(1);
    req(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, W10, 1'b0);

    // Reset in WAIT: outputs drop immediately and the pending access vanishes.
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'hFFC, 32'h0, 4'hF);
    @(negedge clk);
    check("dut1 busy before reset", {31'd0, bus1.busy}, 32'd1);
    drive(1, 1'b1, 1'b1, 32'h20, 32'h0, 4'hF);
    rst_n = 1'b0;
    #1;
    check("dut1 rdata in reset", bus1.resp_rdata, 32'd0);
    check("dut1 outs in reset", {29'd0, bus1.resp_ready, bus1.resp_error, bus1.busy}, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("dut1 busy after reset", {31'd0, bus1.busy}, 32'd0);
    req(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, W10, 1'b0);
    req(1, 1'b0, 1'b1, 32'h20, 32'h0, 4'hF, W10, 1'b0);

    check("scoreboard drained", q1.size() + q0.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
